// File: rtl/pipe_pkg.sv
// pipe_pkg: stage-state encoding and per-boundary field widths shared by the pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_e;

    localparam int XLEN    = 32;
    localparam int PC_W    = 32;
    localparam int REG_AW  = 5;
    localparam int IF_ID_DATA_W  = PC_W + 32;
    localparam int ID_EX_DATA_W  = PC_W + 2 * XLEN + 3 * REG_AW;
    localparam int EX_MEM_DATA_W = 2 * XLEN + REG_AW;
    localparam int MEM_WB_DATA_W = XLEN + REG_AW;
    localparam int STAGE_CTRL_W  = 8;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one data+ctrl+valid entry; clear wins over load and returns ctrl to the bubble value.
module pipe_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
        end
    end

    // Payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_i) data_q <= data_i;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with optional skid entry, flush and drop counting.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int SKID = 1,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    stage_state_e      state_q, state_d;
    logic              up_xfer, dn_xfer;
    logic              main_load, main_clear, main_valid, skid_load, skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl, main_ctrl;
    logic [1:0]        drop_add;
    logic [CNT_W+1:0]  drop_sum;
    logic [CNT_W-1:0]  drop_q, drop_d;

    assign up_xfer    = up_valid_i & up_ready_o;
    assign dn_xfer    = main_valid & dn_ready_i;
    assign main_load  = state_q == ST_SKID ? dn_xfer : up_xfer & (state_q == ST_EMPTY | dn_xfer);
    assign skid_load  = state_q == ST_FULL & up_xfer & ~dn_xfer;
    assign main_clear = flush | (dn_xfer & ~main_load);

    always_comb begin
        state_d = flush ? ST_EMPTY : skid_load ? ST_SKID : main_load ? ST_FULL : dn_xfer ? ST_EMPTY : state_q;
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (state_q == ST_SKID ? skid_data : up_data_i),
        .ctrl_i  (state_q == ST_SKID ? skid_ctrl : up_ctrl_i),
        .valid_o (main_valid),
        .data_o  (dn_data_o),
        .ctrl_o  (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;
            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load_i  (skid_load),
                .clear_i (flush | (state_q == ST_SKID & dn_xfer)),
                .data_i  (up_data_i),
                .ctrl_i  (up_ctrl_i),
                .valid_o (skid_valid),
                .data_o  (skid_data),
                .ctrl_o  (skid_ctrl)
            );
            // Registered from next state so dn_ready_i never reaches up_ready_o combinationally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ready_q <= 1'b1;
                else     ready_q <= state_d != ST_SKID;
            end
            assign up_ready_o = ready_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign up_ready_o = ~main_valid | dn_ready_i;
        end
    endgenerate

    // Entries lost to a flush: held ones not consumed this cycle plus any that arrive with it.
    assign drop_add = {1'b0, main_valid} + {1'b0, skid_valid} - {1'b0, dn_xfer} + {1'b0, up_xfer};
    assign drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, drop_add};
    assign drop_d   = ~flush ? drop_q :
                      drop_sum > {2'b00, {CNT_W{1'b1}}} ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    assign dn_valid_o = main_valid;
    assign dn_ctrl_o  = main_valid ? main_ctrl : BUBBLE_CTRL;
    assign drop_cnt_o = drop_q;

endmodule
